// File: rtl/adv7513_init_sequencer.sv
// Walks the fixed ADV7513 register table, issuing one I2C write per entry with NACK retry.
// One cycle from a response to the next command; Cmd_Valid is held until Cmd_Ready is seen.
module adv7513_init_sequencer #(
  parameter logic [6:0] DEV_ADDR      = 7'h39,
  parameter int         MAX_RETRIES   = 3,
  parameter int         SETTLE_CYCLES = 2000,
  parameter int         RETRY_GAP     = 16
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  output logic       Cmd_Valid,
  input  logic       Cmd_Ready,
  output logic [6:0] Cmd_Dev,
  output logic [7:0] Cmd_Reg,
  output logic [7:0] Cmd_Data,
  input  logic       Rsp_Valid,
  input  logic       Rsp_Nack,
  output logic       Busy,
  output logic       Done,
  output logic       Error,
  output logic [3:0] Fail_Index
);

  localparam int CNT_MAX  = (SETTLE_CYCLES > RETRY_GAP) ? SETTLE_CYCLES : RETRY_GAP;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic [3:0] LAST_IDX = 4'd11;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RSP, SETTLE, GAP, DONE, FAIL} state_t;

  function automatic logic [15:0] table_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    table_entry = 16'h41_10;
      4'd1:    table_entry = 16'h98_03;
      4'd2:    table_entry = 16'h9A_E0;
      4'd3:    table_entry = 16'h9C_30;
      4'd4:    table_entry = 16'h9D_61;
      4'd5:    table_entry = 16'hA2_A4;
      4'd6:    table_entry = 16'hA3_A4;
      4'd7:    table_entry = 16'hE0_D0;
      4'd8:    table_entry = 16'hF9_00;
      4'd9:    table_entry = 16'h15_00;
      4'd10:   table_entry = 16'h16_30;
      4'd11:   table_entry = 16'hAF_04;
      default: table_entry = 16'h00_00;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [3:0]       retries_q, retries_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q, start_d, start_prev_q, start_prev_d;
  logic             auto_q, auto_d, evt_q, evt_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [7:0]       cmd_reg_q, cmd_reg_d, cmd_data_q, cmd_data_d;
  logic             busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [3:0]       fail_idx_q, fail_idx_d;
  logic             load_cmd;
  logic [3:0]       load_idx;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    retries_d    = retries_q;
    cnt_d        = cnt_q;
    start_d      = Start;
    start_prev_d = start_q;
    auto_d       = 1'b0;
    // auto_q is set only by reset, giving exactly one start event after release
    evt_d        = auto_q | (start_q & ~start_prev_q);
    cmd_valid_d  = cmd_valid_q;
    cmd_reg_d    = cmd_reg_q;
    cmd_data_d   = cmd_data_q;
    done_d       = done_q;
    error_d      = error_q;
    fail_idx_d   = fail_idx_q;
    load_cmd     = 1'b0;
    load_idx     = idx_q;

    case (state_q)
      IDLE, DONE, FAIL: begin
        if (evt_q) begin
          state_d   = ISSUE;
          idx_d     = 4'd0;
          retries_d = 4'd0;
          done_d    = 1'b0;
          error_d   = 1'b0;
          load_cmd  = 1'b1;
          load_idx  = 4'd0;
        end
      end
      ISSUE: begin
        if (Cmd_Ready) begin
          state_d     = WAIT_RSP;
          cmd_valid_d = 1'b0;
        end
      end
      WAIT_RSP: begin
        if (Rsp_Valid) begin
          if (!Rsp_Nack) begin
            if (idx_q == 4'd0) begin
              state_d = SETTLE;
              cnt_d   = '0;
            end else if (idx_q == LAST_IDX) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d   = ISSUE;
              idx_d     = idx_q + 4'd1;
              retries_d = 4'd0;
              load_cmd  = 1'b1;
              load_idx  = idx_q + 4'd1;
            end
          end else if (retries_q < 4'(MAX_RETRIES)) begin
            state_d   = GAP;
            retries_d = retries_q + 4'd1;
            cnt_d     = '0;
          end else begin
            state_d    = FAIL;
            error_d    = 1'b1;
            fail_idx_d = idx_q;
          end
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d   = ISSUE;
          idx_d     = 4'd1;
          retries_d = 4'd0;
          load_cmd  = 1'b1;
          load_idx  = 4'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(RETRY_GAP - 1)) begin
          state_d  = ISSUE;
          load_cmd = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_cmd) begin
      cmd_valid_d             = 1'b1;
      {cmd_reg_d, cmd_data_d} = table_entry(load_idx);
    end
    busy_d = !((state_d == IDLE) || (state_d == DONE) || (state_d == FAIL));
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      idx_q        <= 4'd0;
      retries_q    <= 4'd0;
      cnt_q        <= '0;
      start_q      <= 1'b0;
      start_prev_q <= 1'b0;
      auto_q       <= 1'b1;
      evt_q        <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_reg_q    <= 8'h00;
      cmd_data_q   <= 8'h00;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      fail_idx_q   <= 4'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      retries_q    <= retries_d;
      cnt_q        <= cnt_d;
      start_q      <= start_d;
      start_prev_q <= start_prev_d;
      auto_q       <= auto_d;
      evt_q        <= evt_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_reg_q    <= cmd_reg_d;
      cmd_data_q   <= cmd_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      fail_idx_q   <= fail_idx_d;
    end
  end

  assign Cmd_Valid  = cmd_valid_q;
  assign Cmd_Dev    = DEV_ADDR;
  assign Cmd_Reg    = cmd_reg_q;
  assign Cmd_Data   = cmd_data_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Error      = error_q;
  assign Fail_Index = fail_idx_q;

endmodule

// File: tb/tb_adv7513_init_sequencer.sv
// Directed bench for adv7513_init_sequencer: table order, backpressure, retries, failure, restart, reset.
module tb_adv7513_init_sequencer;
  localparam int S    = 20;
  localparam int G    = 5;
  localparam int MAXR = 3;

  logic       Clock = 1'b0, Reset = 1'b1, Start = 1'b0;
  logic       Cmd_Ready = 1'b0, Rsp_Valid = 1'b0, Rsp_Nack = 1'b0;
  logic       Cmd_Valid, Busy, Done, Error;
  logic [6:0] Cmd_Dev;
  logic [7:0] Cmd_Reg, Cmd_Data;
  logic [3:0] Fail_Index;

  int n_checks = 0, n_err = 0;
  int xfer_cnt = 0, e0_cnt = 0;

  typedef struct {
    logic [7:0] r;
    logic [7:0] d;
    int         rdy_dly;
    int         nacks;
  } vec_t;
  vec_t vec[12];

  adv7513_init_sequencer #(
    .DEV_ADDR(7'h39), .MAX_RETRIES(MAXR), .SETTLE_CYCLES(S), .RETRY_GAP(G)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start),
    .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_Dev(Cmd_Dev),
    .Cmd_Reg(Cmd_Reg), .Cmd_Data(Cmd_Data),
    .Rsp_Valid(Rsp_Valid), .Rsp_Nack(Rsp_Nack),
    .Busy(Busy), .Done(Done), .Error(Error), .Fail_Index(Fail_Index)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (Cmd_Valid && Cmd_Ready) begin
      xfer_cnt <= xfer_cnt + 1;
      if (Cmd_Reg == 8'hE0) e0_cnt <= e0_cnt + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Cycles from the current sampling point until Cmd_Valid is seen (1 = already high).
  task automatic wait_cmd(output int lat);
    lat = 1;
    while (Cmd_Valid !== 1'b1 && lat < 300) begin
      tick();
      lat++;
    end
  endtask

  task automatic issue(input int i);
    check("cmd_valid", Cmd_Valid, 1);
    check("cmd_reg_data", {Cmd_Reg, Cmd_Data}, {vec[i].r, vec[i].d});
    for (int k = 0; k < vec[i].rdy_dly; k++) begin
      tick();
      check("hold_stable", {Cmd_Valid, Cmd_Reg, Cmd_Data}, {1'b1, vec[i].r, vec[i].d});
    end
    Cmd_Ready = 1'b1;
    tick();
    Cmd_Ready = 1'b0;
    check("valid_drops", Cmd_Valid, 0);
  endtask

  task automatic respond(input bit nack);
    tick();
    Rsp_Valid = 1'b1;
    Rsp_Nack  = nack;
    tick();
    Rsp_Valid = 1'b0;
    Rsp_Nack  = 1'b0;
  endtask

  task automatic do_entry(input int i, output bit failed);
    failed = 1'b0;
    for (int a = 0; a <= MAXR; a++) begin
      bit nk;
      int lat;
      nk = (a < vec[i].nacks);
      issue(i);
      respond(nk);
      if (nk) begin
        if (a == MAXR) begin
          check("fail_error", Error, 1);
          check("fail_index", Fail_Index, i);
          check("fail_done", Done, 0);
          check("fail_busy", Busy, 0);
          failed = 1'b1;
          return;
        end
        wait_cmd(lat);
        check("retry_gap", lat, G + 1);
      end else begin
        if (i == 11) begin
          check("done", Done, 1);
          check("done_busy", Busy, 0);
          check("done_error", Error, 0);
        end else begin
          wait_cmd(lat);
          check((i == 0) ? "settle_gap" : "next_gap", lat, (i == 0) ? S + 1 : 1);
        end
        return;
      end
    end
  endtask

  initial begin
    int  base, e0base, lat;
    bit  f, quiet;
    logic [15:0] tbl [12];

    tbl = '{16'h4110, 16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61, 16'hA2A4,
            16'hA3A4, 16'hE0D0, 16'hF900, 16'h1500, 16'h1630, 16'hAF04};
    for (int i = 0; i < 12; i++) begin
      vec[i].r       = tbl[i][15:8];
      vec[i].d       = tbl[i][7:0];
      vec[i].rdy_dly = 0;
      vec[i].nacks   = 0;
    end
    vec[3].rdy_dly = 50;
    vec[5].nacks   = 2;

    // Reset state and auto-start timing
    repeat (3) tick();
    check("rst_cmd_valid", Cmd_Valid, 0);
    check("rst_cmd_dev", Cmd_Dev, 7'h39);
    check("rst_cmd_reg", Cmd_Reg, 0);
    check("rst_cmd_data", Cmd_Data, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_error", Error, 0);
    check("rst_fail_index", Fail_Index, 0);
    Reset = 1'b0;
    tick();
    check("auto_cycle1", Cmd_Valid, 0);
    tick();
    check("auto_cycle2", Cmd_Valid, 1);
    check("auto_busy", Busy, 1);

    // Run A: backpressure on 3, two NACKs on 5, Start rising during entry 4
    base = xfer_cnt;
    for (int i = 0; i < 12; i++) begin
      if (i == 4) Start = 1'b1;
      do_entry(i, f);
    end
    check("runA_xfers", xfer_cnt - base, 14);

    Start = 1'b0;
    repeat (3) tick();
    check("done_held", Done, 1);
    check("idle_quiet", Cmd_Valid, 0);
    Start = 1'b1;
    wait_cmd(lat);
    check("restart_latency", lat, 4);
    check("restart_done_clr", Done, 0);
    check("restart_cmd", {Cmd_Reg, Cmd_Data}, 16'h4110);

    // Run B: entry 7 always NACKed
    vec[3].rdy_dly = 0;
    vec[5].nacks   = 0;
    vec[7].nacks   = 4;
    base   = xfer_cnt;
    e0base = e0_cnt;
    for (int i = 0; i < 8; i++) do_entry(i, f);
    check("runB_failed", f, 1);
    check("e0_attempts", e0_cnt - e0base, 4);
    quiet = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (Cmd_Valid !== 1'b0) quiet = 1'b0;
    end
    check("no_cmd_after_fail", quiet, 1);
    check("runB_xfers", xfer_cnt - base, 11);
    check("error_held", Error, 1);

    // Run C: restart from FAIL, then reset while waiting on entry 9
    vec[7].nacks = 0;
    Start = 1'b0;
    tick();
    Start = 1'b1;
    wait_cmd(lat);
    check("fail_restart_latency", lat, 4);
    check("fail_restart_err_clr", Error, 0);
    for (int i = 0; i < 9; i++) do_entry(i, f);
    issue(9);
    tick();
    #3;
    Reset = 1'b1;
    Start = 1'b0;
    #1;
    check("midrst_busy", Busy, 0);
    check("midrst_cmd", {Cmd_Valid, Cmd_Reg, Cmd_Data}, 0);
    check("midrst_fail_index", Fail_Index, 0);
    tick();
    Reset = 1'b0;
    tick();
    check("rerun_cycle1", Cmd_Valid, 0);
    tick();
    check("rerun_cycle2", Cmd_Valid, 1);
    for (int i = 0; i < 12; i++) do_entry(i, f);
    repeat (2) tick();
    check("final_done", {Done, Busy, Error}, 3'b100);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
